// File: rtl/alu_cmd_seq.sv
// Command FIFO feeding a multi-cycle external ALU through an IDLE/LOAD/WAIT/DONE sequencer.
// Optional: define ALU_CMD_SEQ_ONEHOT_CHK_EN to drop non-one-hot commands and pulse err_op.
module alu_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [2:0] in_sel,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [5:0] out_sel,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [5:0] res_op,
    output logic [1:0] state
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
    ,
    output logic       err_op
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 22;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
    function automatic logic is_onehot(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction
`endif

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          empty, full, push, pop, take_head, issue, err_d;
    logic [EW-1:0] head;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    num1_q, num1_d, num2_q, num2_d, res_data_q, res_data_d;
    logic [5:0]    out_sel_q, out_sel_d, res_op_q, res_op_d;
    logic          res_valid_q, res_valid_d, init_q, err_q;

    // Extra pointer bit tells full (MSBs differ) from empty (pointers equal)
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = {cmd_op, cmd_a, cmd_b};
        end
        wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        take_head   = 1'b0;
        case (state_q)
            IDLE: take_head = !empty;
            LOAD: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    res_data_d  = alu_out;
                    res_op_d    = out_sel_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                    take_head   = !empty;
                end
            end
            default: state_d = IDLE;
        endcase
        pop = take_head;
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
        issue = take_head && is_onehot(head[21:16]);
        err_d = take_head && !is_onehot(head[21:16]);
`else
        issue = take_head;
        err_d = 1'b0;
`endif
        if (issue) begin
            state_d   = LOAD;
            out_sel_d = head[21:16];
            num1_d    = head[15:8];
            num2_d    = head[7:0];
        end
    end

    // Payload storage is never reset; pointers define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            out_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            init_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            init_q      <= 1'b0;
            err_q       <= err_d;
        end
    end

    // ALU is held in reset through the first cycle after release
    assign in_sel    = init_q ? 3'b001 : ((state_q == LOAD) ? 3'b010 : 3'b100);
    assign num1      = num1_q;
    assign num2      = num2_q;
    assign out_sel   = out_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign state     = state_q;
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
    assign err_op    = err_q;
`else
    logic unused_err;
    assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: vector table, directed multi-cycle sequences, random traffic vs. a queue scoreboard.
module tb_alu_cmd_seq;
    localparam int FIFO_DEPTH = 4;
    localparam int ALU_LAT    = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, res_valid, res_ready;
    logic [5:0] cmd_op, out_sel, res_op;
    logic [7:0] cmd_a, cmd_b, num1, num2, alu_out, res_data;
    logic [2:0] in_sel;
    logic [1:0] state;
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
    logic       err_op;
`endif

    always #5 clk = ~clk;

    alu_cmd_seq #(.FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .in_sel(in_sel),
        .num1(num1), .num2(num2), .out_sel(out_sel), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .state(state)
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
        , .err_op(err_op)
`endif
    );

    typedef struct packed { logic [5:0] op; logic [7:0] a; logic [7:0] b; } cmd_t;
    typedef struct { logic [5:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] exp; } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   age = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    cmd_t exp_q[$];
    int   hs_cyc[$];
    logic prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [5:0] prev_op;
    logic [7:0] pend = 8'h00;
    vec_t vt [8];

    // Reference ALU behaviour used both by the bench's ALU and by the scoreboard
    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'b000001: return a + b;
            6'b000010: return a - b;
            6'b000100: return a & b;
            6'b001000: return a | b;
            6'b010000: return a ^ b;
            6'b100000: return a;
            default:   return ~(a ^ b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: observe handshakes at the falling edge, update the ALU model just after the rising edge
    task automatic tick();
        logic was_load;
        cmd_t c;
        @(negedge clk);
        if (prev_hold) begin
            chk("hold_res_data", 32'(res_data), 32'(prev_data));
            chk("hold_res_op", 32'(res_op), 32'(prev_op));
        end
        prev_hold = res_valid && !res_ready;
        prev_data = res_data;
        prev_op   = res_op;
        if (cmd_valid && cmd_ready) begin
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
            if ($countones(cmd_op) == 1) exp_q.push_back({cmd_op, cmd_a, cmd_b});
            else err_exp++;
`else
            exp_q.push_back({cmd_op, cmd_a, cmd_b});
`endif
        end
        if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0h op %0h, required none", res_data, res_op);
            end else begin
                c = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(alu_f(c.op, c.a, c.b)));
                chk("res_op", 32'(res_op), 32'(c.op));
            end
        end
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
        if (err_op) err_seen++;
`endif
        was_load = (in_sel == 3'b010);
        if (was_load) pend = alu_f(out_sel, num1, num2);
        @(posedge clk);
        #1;
        cyc++;
        if (was_load) age = 1;
        else if (age > 0) age++;
        alu_out = (age == ALU_LAT) ? pend : ~pend;
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n = 0;
        while (state != s && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic drain(input string name);
        int n = 0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || state != 2'b00) && n < 400) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 0);
    endtask

    task automatic push_cmd(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n0;
        int seen;
        logic [7:0] d0;
        logic [5:0] o0;

        vt[0] = '{6'b000001, 8'h57, 8'h1A, 8'h71};
        vt[1] = '{6'b000010, 8'h57, 8'h1A, 8'h3D};
        vt[2] = '{6'b000100, 8'hF0, 8'h3C, 8'h30};
        vt[3] = '{6'b001000, 8'hF0, 8'h0F, 8'hFF};
        vt[4] = '{6'b010000, 8'hAA, 8'hFF, 8'h55};
        vt[5] = '{6'b100000, 8'h12, 8'h34, 8'h12};
        vt[6] = '{6'b000001, 8'hFF, 8'h02, 8'h01};
        vt[7] = '{6'b000010, 8'h00, 8'h01, 8'hFF};

        cmd_valid = 1'b0; res_ready = 1'b1; cmd_op = '0; cmd_a = '0; cmd_b = '0; alu_out = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_in_sel", 32'(in_sel), 32'h1);
        chk("rst_num1", 32'(num1), 0);
        chk("rst_num2", 32'(num2), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_op", 32'(res_op), 0);
        tick();
        tick();
        rst = 1'b1;
        chk("in_sel_first_cycle", 32'(in_sel), 32'h1);
        tick();
        chk("in_sel_after_first", 32'(in_sel), 32'h4);

        // Single commands: exact cycle-by-cycle sequence
        for (int i = 0; i < 8; i++) begin
            push_cmd(vt[i].op, vt[i].a, vt[i].b);
            tick();
            chk("vec_load_in_sel", 32'(in_sel), 32'h2);
            chk("vec_load_state", 32'(state), 1);
            chk("vec_num1", 32'(num1), 32'(vt[i].a));
            chk("vec_num2", 32'(num2), 32'(vt[i].b));
            chk("vec_out_sel", 32'(out_sel), 32'(vt[i].op));
            for (int k = 0; k < ALU_LAT; k++) begin
                tick();
                chk("vec_wait_in_sel", 32'(in_sel), 32'h4);
                chk("vec_wait_no_valid", 32'(res_valid), 0);
            end
            tick();
            chk("vec_done_valid", 32'(res_valid), 1);
            chk("vec_done_data", 32'(res_data), 32'(vt[i].exp));
            chk("vec_done_op", 32'(res_op), 32'(vt[i].op));
            tick();
            chk("vec_back_idle", 32'(state), 0);
            chk("vec_valid_clr", 32'(res_valid), 0);
        end

        // Five back-to-back pushes with the result stalled: one issued, four queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ready_before_push", 32'(cmd_ready), 1);
            push_cmd(6'(1 << i), 8'(8'h10 + i), 8'(8'h03 * i));
        end
        chk("full_after_5", 32'(cmd_ready), 0);
        wait_state(2'b11, "reach_done");
        d0 = res_data;
        o0 = res_op;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_in_sel", 32'(in_sel), 32'h4);
            chk("stall_state", 32'(state), 3);
            chk("stall_data", 32'(res_data), 32'(d0));
            chk("stall_op", 32'(res_op), 32'(o0));
        end
        res_ready = 1'b1;
        n0 = hs_cyc.size();
        for (int n = 0; n < 100 && hs_cyc.size() < n0 + 5; n++) tick();
        chk("five_results", 32'(hs_cyc.size() - n0), 5);
        for (int k = 1; k < 5 && n0 + k < hs_cyc.size(); k++)
            chk("throughput_gap", 32'(hs_cyc[n0+k] - hs_cyc[n0+k-1]), 32'(ALU_LAT + 2));
        drain("drain_five");

        // Full FIFO with a pop on the same edge as an offered push (pointers already wrapped)
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(6'b000001, 8'(8'h40 + i), 8'h01);
        wait_state(2'b11, "full_reach_done");
        chk("full_ready_low", 32'(cmd_ready), 0);
        cmd_op = 6'b010000; cmd_a = 8'hC3; cmd_b = 8'h3C; cmd_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("full_pop_frees", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk("full_refilled", 32'(cmd_ready), 0);
        drain("drain_full");

        // Reset while waiting on the ALU with three commands queued
        res_ready = 1'b0;
        push_cmd(6'b001000, 8'h01, 8'h02);
        wait_state(2'b11, "rst_seq_done");
        for (int i = 0; i < 4; i++) push_cmd(6'b000100, 8'(8'hA0 + i), 8'hFF);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        wait_state(2'b10, "rst_seq_wait");
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_in_sel", 32'(in_sel), 32'h1);
        chk("midrst_ready", 32'(cmd_ready), 1);
        chk("midrst_valid", 32'(res_valid), 0);
        exp_q.delete();
        prev_hold = 1'b0;
        tick();
        rst = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || state != 2'b00) seen++;
        end
        chk("no_result_after_reset", 32'(seen), 0);

`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
        n0 = err_seen;
        push_cmd(6'b000011, 8'h11, 8'h22);
        push_cmd(6'b000100, 8'h0F, 8'h3C);
        drain("onehot_drain");
        chk("onehot_err_pulses", 32'(err_seen - n0), 1);
`endif

        // Random traffic against the queue scoreboard
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(1, 0) == 1);
            cmd_op    = ($urandom_range(9, 0) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(5, 0));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            res_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        drain("random_drain");
`ifdef ALU_CMD_SEQ_ONEHOT_CHK_EN
        chk("random_err_count", 32'(err_seen), 32'(err_exp));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
